// File: rtl/clkrecv_pkg.sv
// Shared definitions for the clkrecv receive-clock block.
// Contents:
//   state_t    : one-hot state encoding (IDLE, RUNNING, STALLED)
//   idle_level : returns the idle level of the sampled clock from the IDLE_HIGH parameter
package clkrecv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'b001,
        ST_RUNNING = 3'b010,
        ST_STALLED = 3'b100
    } state_t;

    // Idle level of the external clock: 1 when IDLE_HIGH is non-zero.
    function automatic logic idle_level(input int unsigned idle_high);
        return (idle_high != 0);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchronizer for a single asynchronous bit.
// Reset loads every stage with RST_VAL so that no spurious transition is
// seen after reset.
// Parameters:
//   STAGES  : synchronizer depth (>= 2)
//   RST_VAL : value loaded into all stages on reset
// Ports:
//   clk   : destination clock
//   rst_n : synchronous active-low reset
//   d     : asynchronous input
//   q     : synchronized output (last stage)
module sync_ff #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_ff: STAGES must be at least 2");
    end

    logic [STAGES-1:0] stages;

    // Shift chain; stage 0 is the metastability-catching flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stages <= {STAGES{RST_VAL}};
        end else begin
            stages <= {stages[STAGES-2:0], d};
        end
    end

    assign q = stages[STAGES-1];

endmodule

// File: rtl/clkrecv.sv
// Receive-side clock recovery: synchronizes an external slow clock (SPI SCK,
// I2C SCL, ...) into clk_i, produces registered leading/trailing edge strobes,
// measures every half-period, flags short half-periods and detects
// end-of-burst and stuck-clock conditions.
// Optional feature macro: CLKRECV_EDGE_COUNT_EN enables the saturating edge
// counter on edge_count_o; without it edge_count_o is tied to zero.
// Ports:
//   clk_i        : system clock
//   rst_ni       : synchronous active-low reset
//   enable_i     : enables edge detection and measurement
//   sclk_i       : asynchronous external clock
//   sclk_o       : synchronized level of sclk_i
//   lead_o       : one-cycle pulse on a transition away from idle
//   trail_o      : one-cycle pulse on a transition back to idle
//   active_o     : high while RUNNING or STALLED
//   half_o       : last measured half-period (clk_i cycles)
//   half_valid_o : one-cycle pulse when half_o updates
//   glitch_o     : one-cycle pulse when the measured half-period < MIN_HALF
//   done_o       : one-cycle pulse when a burst ends normally
//   stuck_o      : level, clock held non-idle for TIMEOUT cycles
//   edge_count_o : edges counted since reset (optional feature)
module clkrecv
    import clkrecv_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned IDLE_HIGH   = 1,
    parameter int unsigned MIN_HALF    = 4,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 enable_i,
    input  logic                 sclk_i,
    output logic                 sclk_o,
    output logic                 lead_o,
    output logic                 trail_o,
    output logic                 active_o,
    output logic [CNT_WIDTH-1:0] half_o,
    output logic                 half_valid_o,
    output logic                 glitch_o,
    output logic                 done_o,
    output logic                 stuck_o,
    output logic [CNT_WIDTH-1:0] edge_count_o
);

    localparam logic                 IDLE_VAL   = idle_level(IDLE_HIGH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C  = CNT_WIDTH'(TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] MIN_HALF_C = CNT_WIDTH'(MIN_HALF);

    if ((TIMEOUT <= MIN_HALF) || (64'(TIMEOUT) >= ((64'(1) << CNT_WIDTH) - 64'(1)))) begin : g_bad_timeout
        $error("clkrecv: TIMEOUT must exceed MIN_HALF and be below 2**CNT_WIDTH-1");
    end

    state_t               state;
    logic                 prev;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 edge_c;
    logic                 lead_edge_c;
    logic                 trail_edge_c;
    logic [CNT_WIDTH-1:0] cnt_inc_c;

    sync_ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (IDLE_VAL)
    ) u_sync (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .d     (sclk_i),
        .q     (sclk_o)
    );

    // Previous synchronized level; loads idle on reset so no edge follows reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            prev <= IDLE_VAL;
        end else begin
            prev <= sclk_o;
        end
    end

    assign edge_c       = (sclk_o != prev);
    assign lead_edge_c  = edge_c && (sclk_o != IDLE_VAL);
    assign trail_edge_c = edge_c && (sclk_o == IDLE_VAL);
    assign cnt_inc_c    = (cnt == CNT_MAX) ? cnt : (cnt + CNT_ONE);

    // State machine, half-period counter and registered strobes.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            half_o       <= '0;
            lead_o       <= 1'b0;
            trail_o      <= 1'b0;
            half_valid_o <= 1'b0;
            glitch_o     <= 1'b0;
            done_o       <= 1'b0;
            stuck_o      <= 1'b0;
            active_o     <= 1'b0;
        end else begin
            lead_o       <= 1'b0;
            trail_o      <= 1'b0;
            half_valid_o <= 1'b0;
            glitch_o     <= 1'b0;
            done_o       <= 1'b0;
            if (!enable_i) begin
                state    <= ST_IDLE;
                cnt      <= '0;
                stuck_o  <= 1'b0;
                active_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        // A trailing edge here means the input was already
                        // non-idle when enabled; it is ignored.
                        if (lead_edge_c) begin
                            state    <= ST_RUNNING;
                            lead_o   <= 1'b1;
                            cnt      <= CNT_ONE;
                            active_o <= 1'b1;
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_RUNNING: begin
                        // Edge has priority over a simultaneous timeout.
                        if (edge_c) begin
                            lead_o       <= lead_edge_c;
                            trail_o      <= trail_edge_c;
                            half_o       <= cnt;
                            half_valid_o <= 1'b1;
                            glitch_o     <= (cnt < MIN_HALF_C);
                            cnt          <= CNT_ONE;
                        end else if (cnt >= TIMEOUT_C) begin
                            if (sclk_o == IDLE_VAL) begin
                                state    <= ST_IDLE;
                                done_o   <= 1'b1;
                                active_o <= 1'b0;
                                cnt      <= '0;
                            end else begin
                                state   <= ST_STALLED;
                                stuck_o <= 1'b1;
                                cnt     <= cnt_inc_c;
                            end
                        end else begin
                            cnt <= cnt_inc_c;
                        end
                    end
                    ST_STALLED: begin
                        // Release of a stuck clock: no measurement, no done.
                        if (trail_edge_c) begin
                            state    <= ST_IDLE;
                            trail_o  <= 1'b1;
                            stuck_o  <= 1'b0;
                            active_o <= 1'b0;
                            cnt      <= '0;
                        end else begin
                            cnt <= cnt_inc_c;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        cnt      <= '0;
                        stuck_o  <= 1'b0;
                        active_o <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef CLKRECV_EDGE_COUNT_EN
    logic [CNT_WIDTH-1:0] edge_cnt;

    // Saturating count of emitted edge strobes; cleared by reset only.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            edge_cnt <= '0;
        end else if ((lead_o || trail_o) && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + CNT_ONE;
        end
    end

    assign edge_count_o = edge_cnt;
`else
    assign edge_count_o = '0;
`endif

endmodule

// File: doc/clkrecv.md
Name: clkrecv

Overview:
- Receive-side counterpart of the clock divider.
- Samples an externally generated slow clock, such as SPI SCK or I2C SCL, into the clk_i domain.
- Synchronizes the input and produces single-cycle leading and trailing edge strobes for shift and sample logic.
- Measures each half-period, flags half-periods shorter than the protocol minimum, and detects end-of-burst and stuck-clock conditions.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on sclk_i; minimum 2, elaboration fails below that.
- IDLE_HIGH, 1: 1 means sclk_i idles high, 0 means idles low.
- MIN_HALF, 4: minimum legal half-period in clk_i cycles.
- TIMEOUT, 64: clk_i cycles without an edge before a burst is declared ended (or stuck). Must be greater than MIN_HALF and less than 2**CNT_WIDTH-1.
- CNT_WIDTH, 16: width of the half-period counter and of the measurement outputs.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; one clock; reset is synchronous and active-low.
- enable_i  in  1  high enables edge detection and measurement.
- sclk_i  in  1  asynchronous external clock input.
- sclk_o  out  1  synchronized level of sclk_i.
- lead_o  out  1  one-cycle pulse on a transition away from the idle value.
- trail_o  out  1  one-cycle pulse on a transition back to the idle value.
- active_o  out  1  high while in RUNNING or STALLED.
- half_o  out  CNT_WIDTH  last measured half-period in clk_i cycles.
- half_valid_o  out  1  one-cycle pulse when half_o updates.
- glitch_o  out  1  one-cycle pulse when the measured half-period is below MIN_HALF.
- done_o  out  1  one-cycle pulse when a burst ends normally.
- stuck_o  out  1  level; clock held at the non-idle value for TIMEOUT cycles.
- edge_count_o  out  CNT_WIDTH  edges counted since reset (optional feature).

Behaviour:
- Reset (rst_ni low at a clk_i edge):
  - All synchronizer flops and the previous-level register load the idle value, so no edge follows reset.
  - State = IDLE.
  - Counter = 0, half_o = 0.
  - All pulses, active_o and stuck_o = 0; edge_count_o = 0.
  - Reset mid-burst aborts silently with no done_o.
- Edge detection:
  - The last synchronizer stage drives sclk_o; prev holds sclk_o delayed by one clk_i cycle.
  - edge = sclk_o != prev.
  - All strobes are registered, so a change on sclk_i appears on the strobes SYNC_STAGES+1 cycles later.
- Counter:
  - Loaded with 1 on an edge cycle; otherwise increments, saturating at all-ones.
  - Held at 0 in IDLE.
- States (one-hot, 3 bits): IDLE, RUNNING, STALLED. Invalid encodings go to IDLE.
  - IDLE:
    - A leading edge with enable_i high goes to RUNNING, pulses lead_o and loads the counter with 1.
    - A trailing edge seen in IDLE (input was already non-idle at enable) is ignored.
  - RUNNING:
    - Every edge pulses lead_o or trail_o by direction, and captures half_o = counter with a half_valid_o pulse.
    - glitch_o pulses in the same cycle if counter < MIN_HALF.
    - Counter reaching TIMEOUT with sclk_o at idle goes to IDLE and pulses done_o.
    - Counter reaching TIMEOUT with sclk_o non-idle goes to STALLED and sets stuck_o.
  - STALLED:
    - A trailing edge pulses trail_o, clears stuck_o and goes to IDLE. No half_o capture and no done_o.
- enable_i low in any state: next state is IDLE; pulses are suppressed; stuck_o clears; counter = 0. The synchronizer keeps running.
- Edge and TIMEOUT in the same cycle: the edge wins and the counter reloads.
- Counter saturation: half_o reports all-ones; there is no wrap.

Optional Feature:
- CLKRECV_EDGE_COUNT_EN defined:
  - edge_count_o increments on every lead_o or trail_o pulse.
  - Saturates at all-ones.
  - Cleared by reset only.
- Not defined: edge_count_o is tied to 0 and no counter logic is synthesized.

Decomposition:
- clkrecv_pkg:
  - State encodings IDLE=3'b001, RUNNING=3'b010, STALLED=3'b100.
  - Idle-value helper constant derived from IDLE_HIGH.
- Sub-module sync_ff: a SYNC_STAGES-deep synchronizer with a reset-value parameter, reusable elsewhere. The state machine, counter and measurement stay in clkrecv.

Test Plan:
- Reset and no stimulus: hold sclk_i=1 (IDLE_HIGH=1), enable_i=1 for 200 cycles -> no pulses; active_o=0; half_o=0.
- Single burst from a divide-by-8 source: 4 full periods, 4 cycles per level.
  - First lead_o appears exactly 3 cycles after the first fall.
  - Every half_o = 4, with no glitch_o.
  - 4 lead_o and 4 trail_o pulses.
  - done_o fires 64 cycles after the last rise, followed by active_o=0.
- Glitch: in the middle of a burst, drive one low pulse of 2 cycles -> half_o=2 with glitch_o in the same cycle; the burst continues in RUNNING.
- Stuck clock: drive sclk_i low for 100 cycles, then high.
  - stuck_o rises 64 cycles after lead_o.
  - The release produces trail_o, stuck_o=0, state IDLE, and no done_o.
- enable_i dropped mid-burst: active_o falls next cycle; no further strobes; re-enable with sclk_i high gives normal behaviour from the next falling edge.
- Reset mid-burst, with CLKRECV_EDGE_COUNT_EN defined: after 6 edges edge_count_o=6; rst_ni low for 1 cycle -> edge_count_o=0, state IDLE, no done_o.
